vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 98 +++++++++
 tb/tb_vga_sync_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal/vertical pixel counters advanced by a
// pixel-rate enable, with registered sync and visible-area decodes plus
// end-of-line / end-of-frame strobes.
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Decode bounds carry one extra bit so a window ending exactly at the
    // total (zero back porch) still fits.
    localparam logic [HW:0] H_VIS    = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] HS_START = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] V_VIS    = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] VS_START = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024) begin : g_h_total_check
        $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_check
        $error("vga_sync_gen: V_TOTAL exceeds 1024");
    end

    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          h_last, v_last;
    logic          hs_nxt, vs_nxt, vid_nxt;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Next counter values and the decodes of that next position, so the
    // registered outputs line up with the counters on the same edge.
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (pixel_tick) begin
            h_nxt = h_last ? '0 : h_cnt + 1'b1;
            if (h_last) begin
                v_nxt = v_last ? '0 : v_cnt + 1'b1;
            end
        end
        hs_nxt  = ({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END);
        vs_nxt  = ({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END);
        vid_nxt = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
    end

    // Counter and decoded-output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
            video_on <= 1'b1;
        end else begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            hsync    <= hs_nxt ? SYNC_POL : ~SYNC_POL;
            vsync    <= vs_nxt ? SYNC_POL : ~SYNC_POL;
            video_on <= vid_nxt;
        end
    end

    assign pixel_x   = 10'(h_cnt);
    assign pixel_y   = 10'(v_cnt);
    // Strobes are gated by reset so a held tick during reset never pulses.
    assign line_end  = reset & pixel_tick & h_last;
    assign frame_end = line_end & v_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing for horizontal behaviour, freeze and
// reset, plus a 7x6 instance for vertical sync and frame period.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       tick_s;

    logic       d_hsync, d_vsync, d_video, d_lend, d_fend;
    logic [9:0] d_x, d_y;
    logic       s_hsync, s_vsync, s_video, s_lend, s_fend;
    logic [9:0] s_x, s_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk(clk), .reset(reset), .pixel_tick(tick),
        .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video),
        .pixel_x(d_x), .pixel_y(d_y), .line_end(d_lend), .frame_end(d_fend)
    );

    vga_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_s (
        .clk(clk), .reset(reset), .pixel_tick(tick_s),
        .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video),
        .pixel_x(s_x), .pixel_y(s_y), .line_end(s_lend), .frame_end(s_fend)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; returns at the falling edge with post-edge outputs settled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick4();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (3) step();
    endtask

    task automatic burst(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    int pulses;
    int eh, ev;

    initial begin
        reset  = 1'b0;
        tick   = 1'b1;
        tick_s = 1'b0;
        @(negedge clk);
        #1;
        check("lend_in_reset", d_lend, 0);
        check("fend_in_reset", d_fend, 0);
        repeat (3) step();
        check("rst_x", d_x, 0);
        check("rst_y", d_y, 0);
        check("rst_video", d_video, 1);
        check("rst_hsync", d_hsync, 1);
        check("rst_vsync", d_vsync, 1);

        reset = 1'b1;
        tick  = 1'b0;
        step();
        check("idle_x", d_x, 0);
        repeat (639) tick4();
        check("x639", d_x, 639);
        check("video_x639", d_video, 1);
        tick4();
        check("x640", d_x, 640);
        check("video_x640", d_video, 0);
        check("hsync_x640", d_hsync, 1);

        burst(15);
        check("x655", d_x, 655);
        check("hsync_x655", d_hsync, 1);
        burst(1);
        check("hsync_x656", d_hsync, 0);
        burst(95);
        check("x751", d_x, 751);
        check("hsync_x751", d_hsync, 0);
        burst(1);
        check("hsync_x752", d_hsync, 1);
        burst(47);
        check("x799", d_x, 799);
        tick = 1'b1;
        #1;
        check("lend_x799", d_lend, 1);
        check("fend_x799", d_fend, 0);
        step();
        check("wrap_x", d_x, 0);
        check("wrap_y", d_y, 1);
        check("wrap_video", d_video, 1);
        check("lend_after_wrap", d_lend, 0);
        step();
        check("b2b_x1", d_x, 1);
        step();
        check("b2b_x2", d_x, 2);

        burst(698);
        check("x700", d_x, 700);
        tick = 1'b0;
        repeat (1000) step();
        check("frz_x", d_x, 700);
        check("frz_y", d_y, 1);
        check("frz_hsync", d_hsync, 0);
        check("frz_vsync", d_vsync, 1);
        check("frz_video", d_video, 0);
        check("frz_lend", d_lend, 0);
        tick = 1'b1;
        step();
        check("resume_x", d_x, 701);

        burst(99);
        check("line2_x", d_x, 0);
        check("line2_y", d_y, 2);
        burst(799);
        check("x799_y2", d_x, 799);
        check("video_x799", d_video, 0);
        tick  = 1'b1;
        reset = 1'b0;
        #1;
        check("lend_masked", d_lend, 0);
        check("fend_masked", d_fend, 0);
        step();
        step();
        check("mid_rst_x", d_x, 0);
        check("mid_rst_y", d_y, 0);
        check("mid_rst_hsync", d_hsync, 1);
        check("mid_rst_vsync", d_vsync, 1);
        check("mid_rst_video", d_video, 1);
        reset = 1'b1;
        tick  = 1'b0;
        step();
        check("post_rst_x", d_x, 0);
        burst(1);
        check("post_rst_tick_x", d_x, 1);
        check("post_rst_tick_y", d_y, 0);

        // Small instance: held at (0,0) since the last reset.
        pulses = 0;
        for (int n = 0; n < 84; n++) begin
            tick_s = 1'b1;
            #1;
            eh = n % 7;
            ev = (n / 7) % 6;
            check("s_x", s_x, eh);
            check("s_y", s_y, ev);
            check("s_hsync", s_hsync, (eh == 5) ? 0 : 1);
            check("s_vsync", s_vsync, (ev == 4) ? 0 : 1);
            check("s_video", s_video, (eh < 4 && ev < 3) ? 1 : 0);
            check("s_lend", s_lend, (eh == 6) ? 1 : 0);
            check("s_fend", s_fend, (n % 42 == 41) ? 1 : 0);
            if (s_fend) pulses++;
            step();
        end
        tick_s = 1'b0;
        check("s_frame_pulses", pulses, 2);
        check("s_end_x", s_x, 0);
        check("s_end_y", s_y, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
